// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit.
// Single-beat memory handshake with redirect capture and an instruction holding register.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        pc_load,
    input  logic [1:0]  BS_out,
    input  logic [7:0]  PC_out,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  PC_value,
    output logic [7:0]  fetch_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pc;
    logic [7:0] target;
    logic       pending;
    logic       redirect;

    assign redirect = pc_load && (BS_out != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirected or stale response keeps us in FETCH to reissue.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack && !redirect && !pending) state_nxt = HOLD;
            end
            HOLD: begin
                if (redirect || instr_ready) begin
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        PC_value  = pc;
        if (state == FETCH) imem_req = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= 8'h00;
            target      <= 8'h00;
            pending     <= 1'b0;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            fetch_pc    <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        pc          <= PC_out;
                        instr_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        pending <= 1'b0;
                        if (redirect) begin
                            pc <= PC_out;
                        end else if (pending) begin
                            pc <= target;
                        end else begin
                            instr       <= imem_data;
                            fetch_pc    <= pc;
                            pc          <= pc + 8'd1;
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        // Latest redirect wins while the request is in flight.
                        pending <= 1'b1;
                        target  <= PC_out;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc          <= PC_out;
                        instr_valid <= 1'b0;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// Behavioural memory with programmable wait states and an in-order scoreboard.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        pc_load;
    logic [1:0]  BS_out;
    logic [7:0]  PC_out;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  PC_value;
    logic [7:0]  fetch_pc;

    int checks = 0;
    int errors = 0;

    logic        mem_en;
    int          mem_wait;
    int          wcnt;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        man_ack;
    logic [15:0] man_data;

    logic [23:0] sb_q[$];

    typedef struct {
        logic [7:0]  start;
        int          wait_cyc;
        logic [15:0] exp_instr;
        logic [7:0]  exp_fpc;
        logic [7:0]  exp_pcv;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    assign imem_ack  = mem_en ? mem_ack : man_ack;
    assign imem_data = mem_en ? mem_data : man_data;

    pc_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pc_load    (pc_load),
        .BS_out     (BS_out),
        .PC_out     (PC_out),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PC_value   (PC_value),
        .fetch_pc   (fetch_pc)
    );

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (a == 8'h00) return 16'h1234;
        return {a ^ 8'hA5, a};
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers after mem_wait idle cycles of a held request.
    always @(negedge clk) begin
        if (imem_req && !reset) begin
            if (wcnt >= mem_wait) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(imem_addr);
                wcnt     = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 16'hBAD0;
                wcnt     = wcnt + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            mem_data = 16'hBAD0;
            wcnt     = 0;
        end
    end

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(posedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected none",
                         fetch_pc, instr);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                check("sb_instr", instr, e[15:0]);
                check("sb_fetch_pc", {8'h00, fetch_pc}, {8'h00, e[23:16]});
            end
        end
    end

    task automatic set_pc(input logic [7:0] v);
        @(negedge clk);
        run     = 1'b0;
        pc_load = 1'b1;
        BS_out  = 2'b11;
        PC_out  = v;
        @(negedge clk);
        pc_load = 1'b0;
        BS_out  = 2'b00;
        check("set_pc", {8'h00, PC_value}, {8'h00, v});
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no instr_valid expected valid", name);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_valid"}, {15'h0, instr_valid}, 16'h0);
        check({name, "_req"}, {15'h0, imem_req}, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{8'h00, 0, 16'h1234, 8'h00, 8'h01};
        tbl[1] = '{8'hFF, 1, 16'h5AFF, 8'hFF, 8'h00};
        tbl[2] = '{8'h7F, 2, 16'hDA7F, 8'h7F, 8'h80};
        tbl[3] = '{8'h10, 3, 16'hB510, 8'h10, 8'h11};

        reset       = 1'b1;
        run         = 1'b0;
        pc_load     = 1'b0;
        BS_out      = 2'b00;
        PC_out      = 8'h00;
        instr_ready = 1'b0;
        mem_en      = 1'b1;
        mem_wait    = 0;
        wcnt        = 0;
        mem_ack     = 1'b0;
        mem_data    = 16'h0;
        man_ack     = 1'b0;
        man_data    = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_req", {15'h0, imem_req}, 16'h0);
        check("rst_addr", {8'h0, imem_addr}, 16'h0);
        check("rst_instr", instr, 16'h0);
        check("rst_valid", {15'h0, instr_valid}, 16'h0);
        check("rst_pcv", {8'h0, PC_value}, 16'h0);
        check("rst_fpc", {8'h0, fetch_pc}, 16'h0);

        // First fetch from reset with a zero-wait memory.
        reset = 1'b0;
        run   = 1'b1;
        sb_q.push_back({8'h00, 16'h1234});
        @(negedge clk);
        check("first_req", {15'h0, imem_req}, 16'h1);
        check("first_addr", {8'h0, imem_addr}, 16'h0);
        run = 1'b0;
        @(negedge clk);
        check("first_valid", {15'h0, instr_valid}, 16'h1);
        check("first_instr", instr, 16'h1234);
        check("first_fpc", {8'h0, fetch_pc}, 16'h0);
        check("first_pcv", {8'h0, PC_value}, 16'h01);

        // Stall downstream for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_instr", instr, 16'h1234);
            check("hold_valid", {15'h0, instr_valid}, 16'h1);
            check("hold_req", {15'h0, imem_req}, 16'h0);
        end
        instr_ready = 1'b1;
        check_idle("release");

        // BS_out = 00 must not redirect.
        @(negedge clk);
        pc_load = 1'b1;
        BS_out  = 2'b00;
        PC_out  = 8'h99;
        @(negedge clk);
        pc_load = 1'b0;
        check("bs00_ignored", {8'h0, PC_value}, 16'h01);

        // Table of single fetches with varying start pc and wait states.
        foreach (tbl[k]) begin
            set_pc(tbl[k].start);
            mem_wait = tbl[k].wait_cyc;
            run      = 1'b1;
            sb_q.push_back({tbl[k].exp_fpc, tbl[k].exp_instr});
            @(negedge clk);
            run = 1'b0;
            wait_valid("tbl");
            check("tbl_instr", instr, tbl[k].exp_instr);
            check("tbl_fpc", {8'h0, fetch_pc}, {8'h0, tbl[k].exp_fpc});
            check("tbl_pcv", {8'h0, PC_value}, {8'h0, tbl[k].exp_pcv});
            check_idle("tbl_done");
        end

        // Two redirects while a 3-wait fetch of 0x05 is in flight.
        set_pc(8'h05);
        mem_wait = 3;
        run      = 1'b1;
        sb_q.push_back({8'h40, 16'hE540});
        @(negedge clk);
        run     = 1'b0;
        pc_load = 1'b1;
        BS_out  = 2'b11;
        PC_out  = 8'h20;
        @(negedge clk);
        BS_out  = 2'b10;
        PC_out  = 8'h40;
        check("pend_req", {15'h0, imem_req}, 16'h1);
        check("pend_addr", {8'h0, imem_addr}, 16'h05);
        @(negedge clk);
        pc_load = 1'b0;
        BS_out  = 2'b00;
        check("pend_req2", {15'h0, imem_req}, 16'h1);
        check("pend_addr2", {8'h0, imem_addr}, 16'h05);
        @(negedge clk);
        @(negedge clk);
        check("reissue_addr", {8'h0, imem_addr}, 16'h40);
        check("reissue_valid", {15'h0, instr_valid}, 16'h0);
        wait_valid("reissue");
        check("reissue_fpc", {8'h0, fetch_pc}, 16'h40);
        check("reissue_pcv", {8'h0, PC_value}, 16'h41);
        check_idle("reissue_done");

        // Redirect coincident with the memory acknowledge.
        set_pc(8'h30);
        mem_wait = 0;
        run      = 1'b1;
        sb_q.push_back({8'h80, 16'h2580});
        @(negedge clk);
        run     = 1'b0;
        pc_load = 1'b1;
        BS_out  = 2'b01;
        PC_out  = 8'h80;
        @(negedge clk);
        pc_load = 1'b0;
        BS_out  = 2'b00;
        check("coinc_valid", {15'h0, instr_valid}, 16'h0);
        check("coinc_addr", {8'h0, imem_addr}, 16'h80);
        check("coinc_req", {15'h0, imem_req}, 16'h1);
        @(negedge clk);
        check("coinc_fvalid", {15'h0, instr_valid}, 16'h1);
        check("coinc_fpc", {8'h0, fetch_pc}, 16'h80);
        check("coinc_pcv", {8'h0, PC_value}, 16'h81);
        check_idle("coinc_done");

        // Reset in the middle of a handshake, then a stray acknowledge.
        mem_en = 1'b0;
        run    = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("mid_req", {15'h0, imem_req}, 16'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_req", {15'h0, imem_req}, 16'h0);
        check("async_addr", {8'h0, imem_addr}, 16'h0);
        check("async_instr", instr, 16'h0);
        check("async_valid", {15'h0, instr_valid}, 16'h0);
        check("async_pcv", {8'h0, PC_value}, 16'h0);
        check("async_fpc", {8'h0, fetch_pc}, 16'h0);
        @(negedge clk);
        reset    = 1'b0;
        man_ack  = 1'b1;
        man_data = 16'hDEAD;
        @(negedge clk);
        man_ack = 1'b0;
        check("late_valid", {15'h0, instr_valid}, 16'h0);
        check("late_instr", instr, 16'h0);
        check("late_req", {15'h0, imem_req}, 16'h0);
        check("late_pcv", {8'h0, PC_value}, 16'h0);
        mem_en = 1'b1;

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
